sevenseg_scanner: RTL
=====================

Name: sevenseg_scanner

Overview:
- Time-multiplexed scan controller for a DIGITS-wide common-anode/cathode seven-segment display sharing one `sevensegment` decoder.
- Sequences the BCD nibbles through the decoder one digit per slot (MS digit first) and drives one-hot digit enables with a dead-time gap against ghosting.
- Chains the decoder's ripple-blank output across slots for leading-zero suppression.
- Double-buffers the displayed value so a frame never shows a mix of old and new digits.

Parameters:
- DIGITS, 4: number of digits; ≥2.
- CLK_DIV, 1024: clock cycles per digit slot; ≥ DEAD+2.
- DEAD, 16: cycles at the start of each slot with all digit enables low; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  BCD digits; nibble i = digit i, digit DIGITS-1 most significant.
- load  in  1  one-cycle strobe; captures value into pending buffer.
- lz_blank  in  1  1 = suppress leading zeros.
- rbo_in  in  1  ripple-blank output returned from the decoder for the current data/rbi.
- data  out  4  nibble to decoder data input.
- rbi  out  1  ripple-blank input to decoder.
- digit_en  out  DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Decoder contract: rbo_in = rbi & (data==0). When rbi=1 and data=0 the decoder blanks its segments.
- Reset values (all outputs registered):
  - data=0, rbi=0, digit_en=0, frame_done=0.
  - Internal state: prescaler=0, idx=DIGITS-1, active=0, pending=0, pend_valid=0, chain=0.
  - The first slot after reset starts on the first cycle reset is low.
- Prescaler counts 0..CLK_DIV-1, then wraps. Slot boundary is the cycle with prescaler==CLK_DIV-1.
- idx decrements at each slot boundary. After idx 0 it wraps to DIGITS-1, which is the frame boundary.
- Slot outputs:
  - data = active nibble idx for the whole slot.
  - digit_en[idx]=1 only while prescaler ≥ DEAD; all bits 0 while prescaler < DEAD.
  - Never more than one digit_en bit high.
- Ripple-blank chain:
  - rbi for the MS slot = lz_blank, sampled at the frame boundary.
  - rbi for middle slots = chain.
  - rbi for digit 0 is always 0, so a value of 0 shows a single "0".
  - chain <= rbo_in, sampled on the last cycle of each slot.
  - Consequence: a nonzero digit breaks the chain, and later zeros display.
- Buffering:
  - load=1 sets pending<=value and pend_valid<=1; the last load wins.
  - At a frame boundary with pend_valid=1: active<=pending, pend_valid<=0.
  - load on the frame-boundary cycle itself: active<=value directly, pend_valid<=0.
  - active never changes mid-frame.
- frame_done=1 on the cycle after the slot boundary that ends digit 0, i.e. coincident with the first cycle of the new frame's MS slot.
- Latency: load to visible is at most one full frame plus one cycle.
- Reset asserted mid-slot: all state returns to reset values on the next edge, and digit_en drops to 0 that edge. No partial slot completes.
- lz_blank changes mid-frame have no effect until the next frame boundary.

Test Plan (DIGITS=4, CLK_DIV=8, DEAD=2, bench uses the real `sevensegment` decoder for rbo_in):
- Reset then idle, no load → data=0 every slot; rbi sequence per frame 0,0,0,0 with lz_blank=0; digit_en sequence 1000,0100,0010,0001, each high for cycles 2..7 of its slot; frame_done every 32 cycles.
- load value=16'h0120, lz_blank=1 → from next frame: slot3 data=0 rbi=1 (blank), slot2 data=1 rbi=1 (shown), slot1 data=2 rbi=0, slot0 data=0 rbi=0 (shown).
- load 16'h0000, lz_blank=1 → slots 3,2,1 have rbi=1 (blanked); slot0 has rbi=0 and shows "0".
- load 16'h1234 mid-frame, then load 16'h5678 two cycles later → current frame unchanged; next frame shows 5,6,7,8; 1234 never displayed.
- load on the exact frame-boundary cycle with 16'h9999 → the frame starting next cycle shows 9 in all slots.
- Assert reset for one cycle at prescaler=5 of slot 1 → digit_en=0 and data=0 the next cycle; the scan restarts at idx 3 with a full 8-cycle slot; one-hot and dead-time assertions hold throughout.

Source files
------------

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment scan controller: walks BCD digits MS-first through one shared
// decoder, drives one-hot digit enables with a dead-time gap and chains ripple-blank across slots.
module sevenseg_scanner #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 1024,
    parameter int DEAD    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic                  rbo_in,
    output logic [3:0]            data,
    output logic                  rbi,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DEAD_START = PW'(DEAD);
    localparam logic [IW-1:0] IDX_MS     = IW'(DIGITS - 1);

    logic [PW-1:0]          r_presc;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_active;
    logic [4*DIGITS-1:0]    r_pending;
    logic                   r_pendValid;
    logic [3:0]             r_data;
    logic                   r_rbi;
    logic [DIGITS-1:0]      r_digitEn;
    logic                   r_frameDone;

    logic                   w_slotEnd;
    logic                   w_frameEnd;
    logic [PW-1:0]          w_nextPresc;
    logic [IW-1:0]          w_nextIdx;
    logic [4*DIGITS-1:0]    w_nextActive;
    logic [3:0]             w_nextNibble;
    logic [DIGITS-1:0]      w_nextEn;
    logic                   w_nextRbi;

    assign w_slotEnd  = (r_presc == PRESC_LAST);
    assign w_frameEnd = w_slotEnd && (r_idx == '0);

    // Outputs are registered from next-state values so they line up with the slot they describe.
    always_comb begin
        w_nextPresc  = w_slotEnd ? '0 : r_presc + 1'b1;
        w_nextIdx    = r_idx;
        if (w_slotEnd) begin
            w_nextIdx = (r_idx == '0) ? IDX_MS : r_idx - 1'b1;
        end

        w_nextActive = r_active;
        if (w_frameEnd) begin
            if (load) begin
                w_nextActive = value;
            end else if (r_pendValid) begin
                w_nextActive = r_pending;
            end
        end

        w_nextNibble = '0;
        w_nextEn     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_nextIdx == IW'(i)) begin
                w_nextNibble = w_nextActive[i*4 +: 4];
                w_nextEn[i]  = (w_nextPresc >= DEAD_START);
            end
        end

        // The rbi register doubles as the ripple-blank chain: it latches rbo_in at each slot end.
        w_nextRbi = r_rbi;
        if (w_slotEnd) begin
            if (w_nextIdx == IDX_MS) begin
                w_nextRbi = lz_blank;
            end else if (w_nextIdx == '0) begin
                w_nextRbi = 1'b0;
            end else begin
                w_nextRbi = rbo_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc     <= '0;
            r_idx       <= IDX_MS;
            r_active    <= '0;
            r_pending   <= '0;
            r_pendValid <= 1'b0;
            r_data      <= '0;
            r_rbi       <= 1'b0;
            r_digitEn   <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_presc     <= w_nextPresc;
            r_idx       <= w_nextIdx;
            r_active    <= w_nextActive;
            r_data      <= w_nextNibble;
            r_rbi       <= w_nextRbi;
            r_digitEn   <= w_nextEn;
            r_frameDone <= w_frameEnd;
            if (w_frameEnd) begin
                r_pendValid <= 1'b0;
            end else if (load) begin
                r_pending   <= value;
                r_pendValid <= 1'b1;
            end
        end
    end

    assign data       = r_data;
    assign rbi        = r_rbi;
    assign digit_en   = r_digitEn;
    assign frame_done = r_frameDone;

endmodule
